// File: rtl/country_car_sensor_pkg.sv
// Shared definitions for the country-road sensor and the intersection controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package country_car_sensor_pkg;

   // Light code driven by the intersection signal controller
   typedef logic [1:0] light_t;

   localparam light_t RED    = 2'd0;
   localparam light_t YELLOW = 2'd1;
   localparam light_t GREEN  = 2'd2;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Only the exact GREEN code counts as green; the unused code 3 is not green
   function automatic logic is_green(input light_t code);
      return (code == GREEN);
   endfunction

endpackage

// File: rtl/country_car_sensor_loop_debounce.sv
// Inductive-loop conditioner: 2-flop synchronizer, run-length debounce, rise pulse.
// Latency: a stable raw change moves level (and pulses rise) DEB_CYCLES+2 edges after first sample.
// Backpressure: none; rise is a single-cycle pulse and must be consumed when it appears.
module loop_debounce
   import country_car_sensor_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic raw,
   output logic level,
   output logic rise
);

   // Run counter only needs to reach DEB_CYCLES-1; the flip happens on the following sample
   localparam int RUN_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [RUN_W-1:0] run;

   // Bring the asynchronous loop signal into the clock domain
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync1 <= FALSE;
         sync2 <= FALSE;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after DEB_CYCLES consecutive disagreeing samples;
   // any agreeing sample restarts the run, and only 0->1 flips emit a pulse
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         level <= FALSE;
         rise  <= FALSE;
         run   <= '0;
      end else begin
         rise <= FALSE;
         if (sync2 != level) begin
            if (run == RUN_LAST) begin
               level <= sync2;
               rise  <= sync2;
               run   <= '0;
            end else begin
               run <= run + 1'b1;
            end
         end else begin
            run <= '0;
         end
      end
   end

endmodule

// File: rtl/country_car_sensor.sv
// Country-road car tracker: debounced entry/exit loops, waiting-car count, X request, stale watchdog.
// Latency: stable raw rise -> car_count/X update DEB_CYCLES+3 edges later; flush acts on the TIMEOUT-th stale edge.
// Backpressure: none; events are never stalled. Optional stuck-loop detector built with `define SENSOR_FAULT_EN.
module country_car_sensor
   import country_car_sensor_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int CNT_W        = 4,
   parameter int TIMEOUT      = 64,
   parameter int FAULT_CYCLES = 1024
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             arrive_raw,
   input  logic             depart_raw,
   input  logic [1:0]       cntry,
   output logic             X,
   output logic [CNT_W-1:0] car_count,
   output logic             overflow,
   output logic             stale_flush,
   output logic             loop_fault
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

   logic             arrive_level;
   logic             arrive_evt;
   logic             depart_level;
   logic             depart_evt;

   logic [WD_W-1:0]  wd;
   logic [WD_W-1:0]  wd_next;
   logic             flush;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;
   logic             fault_next;

   loop_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_arrive (
      .clock (clock),
      .clear (clear),
      .raw   (arrive_raw),
      .level (arrive_level),
      .rise  (arrive_evt)
   );

   loop_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_depart (
      .clock (clock),
      .clear (clear),
      .raw   (depart_raw),
      .level (depart_level),
      .rise  (depart_evt)
   );

   // The exit level itself is not needed (only its rise); the entry level feeds the fault detector when built
   logic unused_levels;
   assign unused_levels = arrive_level ^ depart_level;

   // Next-state for watchdog and counter: a flush beats any arrival; coincident arrive+depart cancel out
   always_comb begin
      flush    = FALSE;
      wd_next  = '0;
      cnt_next = car_count;
      ovf_next = overflow;

      if (is_green(cntry) && (car_count != '0) && !depart_evt) begin
         if (wd == WD_LAST) begin
            flush = TRUE;
         end else begin
            wd_next = wd + 1'b1;
         end
      end

      if (flush) begin
         cnt_next = '0;
      end else if (arrive_evt && !depart_evt) begin
         if (car_count == CNT_MAX) begin
            ovf_next = TRUE;
         end else begin
            cnt_next = car_count + 1'b1;
         end
      end else if (depart_evt && !arrive_evt) begin
         if (car_count != '0) begin
            cnt_next = car_count - 1'b1;
         end
      end
   end

`ifdef SENSOR_FAULT_EN
   localparam int              FC_W    = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FAULT_CYCLES - 1);

   logic [FC_W-1:0] fault_cnt;
   logic            fault_q;

   // Entry loop stuck high for FAULT_CYCLES edges latches the fault until clear
   assign fault_next = fault_q | (arrive_level && (fault_cnt == FC_LAST));
   assign loop_fault = fault_q;

   // Measure how long the debounced entry level has been continuously high
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         fault_cnt <= '0;
         fault_q   <= FALSE;
      end else begin
         fault_q <= fault_next;
         if (arrive_level) begin
            if (fault_cnt != FC_LAST) begin
               fault_cnt <= fault_cnt + 1'b1;
            end
         end else begin
            fault_cnt <= '0;
         end
      end
   end
`else
   assign fault_next = FALSE;
   assign loop_fault = FALSE;
`endif

   // Register count, request and status; X follows the new count (or the fail-safe fault)
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         car_count   <= '0;
         overflow    <= FALSE;
         stale_flush <= FALSE;
         X           <= FALSE;
         wd          <= '0;
      end else begin
         car_count   <= cnt_next;
         overflow    <= ovf_next;
         stale_flush <= flush;
         X           <= fault_next | (cnt_next != '0);
         wd          <= flush ? '0 : wd_next;
      end
   end

endmodule

// File: tb/tb_country_car_sensor.sv
// Bench for country_car_sensor: directed scenarios then random loop activity against a reference model.
// Latency: model predicts outputs edge by edge; outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_country_car_sensor;

   localparam int DEB  = 4;
   localparam int CW   = 4;
   localparam int TO   = 64;
   localparam int FC   = 16;
   localparam int MAXC = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          arrive_raw = 1'b0;
   logic          depart_raw = 1'b0;
   logic [1:0]    cntry = 2'd0;
   logic          X;
   logic [CW-1:0] car_count;
   logic          overflow;
   logic          stale_flush;
   logic          loop_fault;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   country_car_sensor #(
      .DEB_CYCLES   (DEB),
      .CNT_W        (CW),
      .TIMEOUT      (TO),
      .FAULT_CYCLES (FC)
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .arrive_raw  (arrive_raw),
      .depart_raw  (depart_raw),
      .cntry       (cntry),
      .X           (X),
      .car_count   (car_count),
      .overflow    (overflow),
      .stale_flush (stale_flush),
      .loop_fault  (loop_fault)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   // Debounce is modelled as "the last DEB synchronized samples (raw delayed by two edges)
   // all disagree with the accepted level"; count follows the arrive/depart/flush rules.
   int m_cnt, m_wd, m_fc;
   bit m_ovf, m_x, m_flush, m_fault;
   bit m_ea, m_ed;
   bit m_lv_a, m_lv_d;
   int m_since_a, m_since_d;
   bit ha[$];
   bit hd[$];

   function automatic bit deb_flip(input bit h[$], input bit lv, input int since);
      if (since < DEB) return 1'b0;
      for (int i = 0; i < DEB; i++)
         if (h[h.size() - 3 - i] == lv) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_wd = 0; m_fc = 0;
      m_ovf = 0; m_x = 0; m_flush = 0; m_fault = 0;
      m_ea = 0; m_ed = 0; m_lv_a = 0; m_lv_d = 0;
      m_since_a = 0; m_since_d = 0;
      ha.delete(); hd.delete();
      for (int i = 0; i < DEB + 2; i++) begin
         ha.push_back(1'b0);
         hd.push_back(1'b0);
      end
   endtask

   task automatic model_edge(input bit a, input bit d, input logic [1:0] c);
      bit fl;
      fl = 1'b0;
      if (c == 2'd2 && m_cnt != 0 && !m_ed) begin
         if (m_wd + 1 == TO) begin fl = 1'b1; m_wd = 0; end
         else m_wd++;
      end else begin
         m_wd = 0;
      end
      if (fl) m_cnt = 0;
      else if (m_ea && !m_ed) begin
         if (m_cnt == MAXC) m_ovf = 1'b1;
         else m_cnt++;
      end else if (m_ed && !m_ea && m_cnt > 0) begin
         m_cnt--;
      end
`ifdef SENSOR_FAULT_EN
      if (m_lv_a) begin
         m_fc++;
         if (m_fc >= FC) m_fault = 1'b1;
      end else begin
         m_fc = 0;
      end
`endif
      m_flush = fl;
      m_x = m_fault || (m_cnt != 0);

      ha.push_back(a); hd.push_back(d);
      m_since_a++; m_since_d++;
      m_ea = 1'b0; m_ed = 1'b0;
      if (deb_flip(ha, m_lv_a, m_since_a)) begin
         m_lv_a = !m_lv_a; m_since_a = 0; m_ea = m_lv_a;
      end
      if (deb_flip(hd, m_lv_d, m_since_d)) begin
         m_lv_d = !m_lv_d; m_since_d = 0; m_ed = m_lv_d;
      end
      while (ha.size() > DEB + 4) void'(ha.pop_front());
      while (hd.size() > DEB + 4) void'(hd.pop_front());
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("car_count", 32'(car_count), 32'(m_cnt));
      chk("X", 32'(X), 32'(m_x));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("stale_flush", 32'(stale_flush), 32'(m_flush));
      chk("loop_fault", 32'(loop_fault), 32'(m_fault));
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge(arrive_raw, depart_raw, cntry);
      #1;
      check_all();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #2;
      chk("clr_count", 32'(car_count), 32'd0);
      chk("clr_X", 32'(X), 32'd0);
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_flush", 32'(stale_flush), 32'd0);
      chk("clr_fault", 32'(loop_fault), 32'd0);
      clear = 1'b0;
      model_reset();
   endtask

   task automatic pulse(input bit a, input bit d, input int hi, input int lo);
      arrive_raw = a;
      depart_raw = d;
      repeat (hi) tick();
      arrive_raw = 1'b0;
      depart_raw = 1'b0;
      repeat (lo) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int flushes;
      int pa, pd;
      model_reset();

      // Reset state
      #12;
      chk("rst_count", 32'(car_count), 32'd0);
      chk("rst_X", 32'(X), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_flush", 32'(stale_flush), 32'd0);
      chk("rst_fault", 32'(loop_fault), 32'd0);
      clear = 1'b0;

      // Single arrival: count and X rise exactly on the 7th edge
      arrive_raw = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 6) chk("lat_before", 32'(car_count), 32'd0);
         if (e == 7) begin
            chk("lat_count", 32'(car_count), 32'd1);
            chk("lat_X", 32'(X), 32'd1);
         end
      end
      arrive_raw = 1'b0;
      repeat (10) tick();
      chk("single_count", 32'(car_count), 32'd1);

      // Bouncy entry loop never settles long enough
      for (int i = 0; i < 10; i++) begin
         arrive_raw = ~arrive_raw;
         repeat (2) tick();
      end
      arrive_raw = 1'b0;
      repeat (8) tick();
      chk("bounce_count", 32'(car_count), 32'd1);

      // Three arrivals, then four departures on green
      do_clear();
      repeat (3) pulse(1'b1, 1'b0, 8, 8);
      chk("arr3_count", 32'(car_count), 32'd3);
      cntry = 2'd2;
      repeat (4) pulse(1'b0, 1'b1, 8, 8);
      chk("dep4_count", 32'(car_count), 32'd0);
      chk("dep4_X", 32'(X), 32'd0);

      // Saturation with overflow, then coincident arrive+depart
      cntry = 2'd0;
      repeat (MAXC + 1) pulse(1'b1, 1'b0, 6, 6);
      chk("sat_count", 32'(car_count), 32'(MAXC));
      chk("sat_overflow", 32'(overflow), 32'd1);
      repeat (2) pulse(1'b1, 1'b1, 6, 6);
      chk("both_count", 32'(car_count), 32'(MAXC));

      // Stale count on green gets flushed exactly once
      cntry = 2'd2;
      flushes = 0;
      repeat (TO + 6) begin
         tick();
         if (stale_flush) flushes++;
      end
      chk("wd_flushes", 32'(flushes), 32'd1);
      chk("wd_count", 32'(car_count), 32'd0);
      chk("wd_X", 32'(X), 32'd0);

      // Same waiting cars on red are never flushed
      cntry = 2'd0;
      repeat (2) pulse(1'b1, 1'b0, 6, 6);
      flushes = 0;
      repeat (TO + 16) begin
         tick();
         if (stale_flush) flushes++;
      end
      chk("red_flushes", 32'(flushes), 32'd0);
      chk("red_count", 32'(car_count), 32'd2);

      // Entry loop held high for a long time
      do_clear();
      pulse(1'b1, 1'b0, 40, 10);
`ifdef SENSOR_FAULT_EN
      chk("fault_set", 32'(loop_fault), 32'd1);
      chk("fault_X", 32'(X), 32'd1);
`else
      chk("fault_off", 32'(loop_fault), 32'd0);
`endif
      do_clear();
      tick();

      // Random loop activity with occasional illegal light code and mid-run clear
      for (int blk = 0; blk < 15; blk++) begin
         pa = $urandom_range(2, 40);
         pd = $urandom_range(2, 40);
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, pa - 1) == 0) arrive_raw = ~arrive_raw;
            if ($urandom_range(0, pd - 1) == 0) depart_raw = ~depart_raw;
            if ($urandom_range(0, 29) == 0) cntry = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) do_clear();
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
